// File: rtl/spi_rx_deserializer_if.sv
// spi_rx_deserializer_if: RX FIFO read/status bus between the SPI receive path and the register block.
// Signals:
//   pop       register block -> deserializer, one-cycle pulse that removes the head word
//   ov_clear  register block -> deserializer, one-cycle pulse that clears the sticky overflow flag
//   data_out  head word, show-ahead, 0 when empty
//   fe/ff/fo  empty / full / sticky overflow
//   level     number of words held, 0..2**PW
// Modports: master = register block, slave = deserializer.
interface spi_rx_deserializer_if #(
    parameter int M  = 32,
    parameter int PW = 4
);
    logic          pop;
    logic          ov_clear;
    logic [M-1:0]  data_out;
    logic          fe;
    logic          ff;
    logic          fo;
    logic [PW:0]   level;

    modport master (output pop, ov_clear, input data_out, fe, ff, fo, level);
    modport slave  (input pop, ov_clear, output data_out, fe, ff, fo, level);
endinterface

// File: rtl/spi_rx_deserializer.sv
// spi_rx_deserializer: SPI receive path that samples rx on sclk edges, assembles MSB-first words and queues them in an RX FIFO.
// Ports:
//   clk, reset   system clock, synchronous active-high reset
//   enable       low forces the FSM to IDLE (FIFO contents kept)
//   sclk         serial clock, generated synchronously in the clk domain
//   active       high while the serializer is transferring
//   word_len     bits per word 1..31, 0 disables capture
//   sample_fall  1 = sample on falling sclk edge, 0 = rising
//   rx           asynchronous serial data
//   bus          FIFO read/status interface (slave side)
module spi_rx_deserializer #(
    parameter int N  = 16,
    parameter int M  = 32,
    parameter int PW = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       sclk,
    input  logic       active,
    input  logic [4:0] word_len,
    input  logic       sample_fall,
    input  logic       rx,
    spi_rx_deserializer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, PUSH} state_t;

    state_t        state_q, state_d;
    logic          rx_m_q, rx_s_q, sclk_q;
    logic [4:0]    cnt_q, cnt_d;
    logic [M-1:0]  shift_q, shift_d;
    logic [M-1:0]  mem_q [N];
    logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [PW:0]   level_q, level_d;
    logic          fo_q, fo_d;
    logic          smp, push, fe, ff, do_push, do_pop, ovf;

    assign smp = sample_fall ? (~sclk & sclk_q) : (sclk & ~sclk_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        case (state_q)
            IDLE: if (active && word_len != 5'd0) begin
                state_d = SHIFT;
                cnt_d   = word_len;
                shift_d = '0;
            end
            SHIFT: if (smp) begin
                shift_d = {shift_q[M-2:0], rx_s_q};
                cnt_d   = cnt_q - 5'd1;
                // the final bit completes the word even if active drops in the same cycle
                state_d = (cnt_q == 5'd1) ? PUSH : (active ? SHIFT : IDLE);
            end else if (!active) begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (!enable) state_d = IDLE;
    end

    assign fe      = (level_q == '0);
    assign ff      = (level_q == (PW+1)'(N));
    assign push    = (state_q == PUSH);
    assign do_pop  = bus.pop & ~fe;
    // a pop in the same cycle frees a slot, so a full FIFO still accepts the word
    assign do_push = push & (~ff | bus.pop);
    assign ovf     = push & ff & ~bus.pop;

    always_comb begin
        wp_d    = wp_q + PW'(do_push);
        rp_d    = rp_q + PW'(do_pop);
        level_d = level_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
        fo_d    = ovf | (fo_q & ~bus.ov_clear);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            rx_m_q  <= 1'b0;
            rx_s_q  <= 1'b0;
            sclk_q  <= 1'b0;
            cnt_q   <= '0;
            shift_q <= '0;
            wp_q    <= '0;
            rp_q    <= '0;
            level_q <= '0;
            fo_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rx_m_q  <= rx;
            rx_s_q  <= rx_m_q;
            sclk_q  <= sclk;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            level_q <= level_d;
            fo_q    <= fo_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wp_q] <= shift_q;
    end

    assign bus.data_out = fe ? '0 : mem_q[rp_q];
    assign bus.fe       = fe;
    assign bus.ff       = ff;
    assign bus.fo       = fo_q;
    assign bus.level    = level_q;
endmodule

// File: tb/tb_spi_rx_deserializer.sv
// tb_spi_rx_deserializer: directed scoreboard bench for the SPI RX deserializer and its FIFO.
module tb_spi_rx_deserializer;
    localparam int H = 5;

    logic       clk = 1'b0;
    logic       reset, enable, sclk, active, sample_fall, rx;
    logic [4:0] word_len;
    logic       mon_en = 1'b0, mon_pop = 1'b0, sync_pop = 1'b0;
    int         checks = 0, errors = 0;
    logic [31:0] exp_q[$];

    spi_rx_deserializer_if #(.M(32), .PW(4)) itf ();

    spi_rx_deserializer #(.N(16), .M(32), .PW(4)) dut (
        .clk(clk), .reset(reset), .enable(enable), .sclk(sclk), .active(active),
        .word_len(word_len), .sample_fall(sample_fall), .rx(rx), .bus(itf.slave)
    );

    assign itf.pop = mon_pop | sync_pop;

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    // stop_at >= 0 aborts after that many bits; pop_last pops in the cycle the word is written
    task automatic send_frame(input logic [31:0] w, input int n, input int stop_at, input bit pop_last);
        active = 1'b1;
        wait_clk(3);
        for (int i = n - 1; i >= 0; i--) begin
            if (stop_at >= 0 && (n - 1 - i) == stop_at) break;
            rx = w[i];
            wait_clk(H);
            sclk = 1'b1;
            wait_clk(H);
            sclk = 1'b0;
            if (pop_last && i == 0) begin
                @(posedge clk);
                #1;
                chk("coinc_head", itf.data_out, exp_q[0]);
                void'(exp_q.pop_front());
                sync_pop = 1'b1;
                @(posedge clk);
                #1;
                sync_pop = 1'b0;
            end
            wait_clk(H);
        end
        active = 1'b0;
        wait_clk(H);
    endtask

    task automatic drain();
        int t = 0;
        mon_en = 1'b1;
        while ((exp_q.size() != 0 || !itf.fe) && t < 400) begin
            wait_clk(1);
            t++;
        end
        chk("drain_done", {31'd0, exp_q.size() == 0 && itf.fe}, 32'd1);
        mon_en = 1'b0;
        wait_clk(2);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (mon_pop) mon_pop = 1'b0;
            else if (mon_en && !itf.fe) begin
                if (exp_q.size() == 0) chk("unexpected_word", itf.data_out, 32'hxxxxxxxx);
                else chk("scoreboard", itf.data_out, exp_q.pop_front());
                mon_pop = 1'b1;
            end
        end
    end

    initial begin
        reset = 1'b1; enable = 1'b1; sclk = 1'b0; active = 1'b0; sample_fall = 1'b1;
        rx = 1'b0; word_len = 5'd8; itf.ov_clear = 1'b0;
        wait_clk(3);
        reset = 1'b0;
        wait_clk(1);
        chk("rst_fe", {31'd0, itf.fe}, 32'd1);
        chk("rst_ff", {31'd0, itf.ff}, 32'd0);
        chk("rst_fo", {31'd0, itf.fo}, 32'd0);
        chk("rst_level", {27'd0, itf.level}, 32'd0);
        chk("rst_data", itf.data_out, 32'd0);

        send_frame(32'hA5, 8, -1, 1'b0);
        exp_q.push_back(32'h000000A5);
        chk("a5_data", itf.data_out, 32'h000000A5);
        chk("a5_fe", {31'd0, itf.fe}, 32'd0);
        chk("a5_level", {27'd0, itf.level}, 32'd1);
        drain();

        for (int i = 1; i <= 17; i++) begin
            send_frame(32'(i), 8, -1, 1'b0);
            if (i <= 16) exp_q.push_back(32'(i));
        end
        chk("full_ff", {31'd0, itf.ff}, 32'd1);
        chk("full_fo", {31'd0, itf.fo}, 32'd1);
        chk("full_level", {27'd0, itf.level}, 32'd16);
        drain();
        chk("fo_sticky", {31'd0, itf.fo}, 32'd1);
        itf.ov_clear = 1'b1;
        wait_clk(1);
        itf.ov_clear = 1'b0;
        chk("fo_cleared", {31'd0, itf.fo}, 32'd0);

        for (int i = 0; i < 16; i++) begin
            send_frame(32'h20 + 32'(i), 8, -1, 1'b0);
            exp_q.push_back(32'h20 + 32'(i));
        end
        send_frame(32'h55, 8, -1, 1'b1);
        exp_q.push_back(32'h55);
        chk("coinc_fo", {31'd0, itf.fo}, 32'd0);
        chk("coinc_level", {27'd0, itf.level}, 32'd16);
        drain();

        sample_fall = 1'b0;
        word_len = 5'd31;
        send_frame(32'h7FFFFFFF, 31, -1, 1'b0);
        exp_q.push_back(32'h7FFFFFFF);
        chk("w31_data", itf.data_out, 32'h7FFFFFFF);
        drain();

        word_len = 5'd0;
        mon_en = 1'b1;
        send_frame(32'hFF, 8, -1, 1'b0);
        chk("wl0_fe", {31'd0, itf.fe}, 32'd1);
        chk("wl0_level", {27'd0, itf.level}, 32'd0);
        mon_en = 1'b0;

        sample_fall = 1'b1;
        word_len = 5'd8;
        send_frame(32'hFF, 8, 3, 1'b0);
        chk("abort_fe", {31'd0, itf.fe}, 32'd1);
        send_frame(32'h3C, 8, -1, 1'b0);
        exp_q.push_back(32'h3C);
        drain();

        send_frame(32'h11, 8, -1, 1'b0);
        send_frame(32'h22, 8, -1, 1'b0);
        chk("pre_rst_level", {27'd0, itf.level}, 32'd2);
        active = 1'b1;
        wait_clk(3);
        rx = 1'b1;
        wait_clk(H);
        sclk = 1'b1;
        wait_clk(H);
        sclk = 1'b0;
        wait_clk(2);
        reset = 1'b1;
        wait_clk(1);
        reset = 1'b0;
        active = 1'b0;
        chk("midrst_fe", {31'd0, itf.fe}, 32'd1);
        chk("midrst_level", {27'd0, itf.level}, 32'd0);
        chk("midrst_fo", {31'd0, itf.fo}, 32'd0);
        chk("midrst_data", itf.data_out, 32'd0);
        wait_clk(H);
        sync_pop = 1'b1;
        wait_clk(1);
        sync_pop = 1'b0;
        chk("empty_pop_level", {27'd0, itf.level}, 32'd0);
        chk("empty_pop_fe", {31'd0, itf.fe}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
